// File: rtl/uart_rx_param_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_rx_param_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } rx_state_e;

    localparam logic [1:0] PARITY_NONE  = 2'b00;
    localparam logic [1:0] PARITY_EVEN  = 2'b01;
    localparam logic [1:0] PARITY_ODD   = 2'b10;
    localparam logic [1:0] PARITY_NONE2 = 2'b11;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer handshake: held frame, flags and valid/ready.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 valid;
    logic                 ready;
    logic [DATA_BITS-1:0] data;
    logic                 par_err;
    logic                 frame_err;
    logic                 ovr_err;

    modport master (output valid, data, par_err, frame_err, ovr_err, input ready);
    modport slave  (input valid, data, par_err, frame_err, ovr_err, output ready);
endinterface

// File: rtl/uart_rx_param_baud_tick.sv
// Oversample tick generator: counts 0..i_div and pulses o_tick on wrap; shared with the TX side.
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_sclr,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    // >= so a divisor lowered below the running count wraps at once
    assign w_wrap = (r_cnt >= i_div);
    assign o_tick = w_wrap & ~i_restart & ~i_sclr;

    always_ff @(posedge i_clk) begin
        if (i_sclr || i_restart) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority sampling, parity/framing/overrun flags and valid/ready.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVS         = 16,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_sclk,
    input  logic             i_sclr,
    input  logic [DIV_W-1:0] i_baud_div,
    input  logic [1:0]       i_parity_mode,
    input  logic             i_stop2,
    input  logic             i_rx,
    uart_rx_param_if.master  rx_if,
    output logic             o_rx_busy,
    output logic             o_rx_break
);
    localparam int unsigned SCW = $clog2(OVS);
    localparam int unsigned BCW = $clog2(DATA_BITS + 1);
    localparam logic [SCW-1:0] SMP0  = SCW'(OVS / 2 - 1);
    localparam logic [SCW-1:0] SMP1  = SCW'(OVS / 2);
    localparam logic [SCW-1:0] SMPD  = SCW'(OVS / 2 + 1);
    localparam logic [SCW-1:0] SLAST = SCW'(OVS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_e              r_state;
    logic [SCW-1:0]         r_scnt;
    logic [BCW-1:0]         r_bcnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_s0, r_s1, r_par, r_perr, r_ferr, r_stop2, r_stop_idx;
    logic [1:0]             r_pmode;
    logic                   r_out_valid, r_out_perr, r_out_ferr, r_out_ovr;
    logic [DATA_BITS-1:0]   r_out_data;
    logic                   w_rx_s, w_start, w_tick, w_mid, w_end, w_bit;
    logic                   w_last_stop, w_ferr_now, w_complete;

    always_ff @(posedge i_sclk) begin
        if (i_sclr) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
    end

    // Low level in IDLE is a start; a line stuck low therefore yields one frame per frame time
    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_start     = (r_state == StIdle) & ~w_rx_s;
    assign w_mid       = w_tick & (r_scnt == SMPD);
    assign w_end       = w_tick & (r_scnt == SLAST);
    assign w_bit       = majority3(r_s0, r_s1, w_rx_s);
    assign w_last_stop = ~r_stop2 | r_stop_idx;
    assign w_ferr_now  = r_ferr | ~w_bit;

`ifdef UART_RX_BREAK_DET_EN
    logic r_break;
    logic w_break;
    assign w_break    = w_mid & (r_state == StStop) & ~r_stop_idx & ~w_bit & (r_shift == '0);
    assign w_complete = w_mid & (r_state == StStop) & w_last_stop & ~w_break;
    assign o_rx_break = r_break;
`else
    assign w_complete = w_mid & (r_state == StStop) & w_last_stop;
    assign o_rx_break = 1'b0;
`endif

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_tick (
        .i_clk    (i_sclk),
        .i_sclr   (i_sclr),
        .i_restart(w_start),
        .i_div    (i_baud_div),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_sclk) begin
        if (i_sclr) begin
            r_state    <= StIdle;
            r_scnt     <= '0;
            r_bcnt     <= '0;
            r_shift    <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_par      <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_pmode    <= PARITY_NONE;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_break    <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_BREAK_DET_EN
            r_break <= 1'b0;
`endif
            if (w_tick) begin
                r_scnt <= (r_scnt == SLAST) ? '0 : r_scnt + 1'b1;
                if (r_scnt == SMP0) r_s0 <= w_rx_s;
                if (r_scnt == SMP1) r_s1 <= w_rx_s;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_state    <= StStart;
                        r_scnt     <= '0;
                        r_bcnt     <= '0;
                        r_par      <= 1'b0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_stop_idx <= 1'b0;
                        r_pmode    <= i_parity_mode;
                        r_stop2    <= i_stop2;
                    end
                end
                StStart: begin
                    if (w_mid && w_bit) r_state <= StIdle;
                    else if (w_end)     r_state <= StData;
                end
                StData: begin
                    if (w_mid) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_bit;
                        r_bcnt  <= r_bcnt + 1'b1;
                    end
                    if (w_end && r_bcnt == BCW'(DATA_BITS)) begin
                        case (r_pmode)
                            PARITY_EVEN, PARITY_ODD:   r_state <= StParity;
                            PARITY_NONE, PARITY_NONE2: r_state <= StStop;
                        endcase
                    end
                end
                StParity: begin
                    if (w_mid) r_perr <= r_par ^ w_bit ^ (r_pmode == PARITY_ODD);
                    if (w_end) r_state <= StStop;
                end
                StStop: begin
                    if (w_mid) begin
                        r_ferr <= w_ferr_now;
`ifdef UART_RX_BREAK_DET_EN
                        if (w_break) begin
                            r_state <= StBreakWait;
                            r_break <= 1'b1;
                        end else
`endif
                        if (w_last_stop) r_state <= StIdle;
                    end
                    if (w_end) r_stop_idx <= 1'b1;
                end
`ifdef UART_RX_BREAK_DET_EN
                StBreakWait: begin
                    if (w_rx_s) r_state <= StIdle;
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

    // Output hold register: a completion while a frame is pending and not taken is dropped
    always_ff @(posedge i_sclk) begin
        if (i_sclr) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
            r_out_ferr  <= 1'b0;
            r_out_ovr   <= 1'b0;
        end else if (w_complete) begin
            if (!r_out_valid || rx_if.ready) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_shift;
                r_out_perr  <= r_perr;
                r_out_ferr  <= w_ferr_now;
                r_out_ovr   <= 1'b0;
            end else begin
                r_out_ovr <= 1'b1;
            end
        end else if (r_out_valid && rx_if.ready) begin
            r_out_valid <= 1'b0;
            r_out_perr  <= 1'b0;
            r_out_ferr  <= 1'b0;
            r_out_ovr   <= 1'b0;
        end
    end

    assign rx_if.valid     = r_out_valid;
    assign rx_if.data      = r_out_data;
    assign rx_if.par_err   = r_out_perr;
    assign rx_if.frame_err = r_out_ferr;
    assign rx_if.ovr_err   = r_out_ovr;
    assign o_rx_busy       = (r_state != StIdle);
endmodule
